rv32i_alu_issue: RTL

- Execute-stage front end for the rv32i core. It drives the existing combinational alu from the issuing side.
- Accepts one decoded-register-read instruction per cycle over a valid/ready handshake.
- Decodes opcode/funct3/funct7 into alu_op_t, selects operands, presents them to the alu, and registers the result with destination info.
- Two-stage pipeline (D = decode/operand register, W = result register) with full backpressure.

---
 rtl/rv32i_pkg.sv | 34 +++
 rtl/rv32i_alu_issue_if.sv | 46 ++++
 rtl/rv32i_alu_issue.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared rv32i types: ALU operation codes and the
// bundles passed between the issue D and W stages.
package rv32i_pkg;

  localparam int DPW = 32;

  typedef enum logic [2:0] {
    ADD_OP = 3'd0,
    SUB_OP = 3'd1,
    SLL_OP = 3'd2,
    XOR_OP = 3'd3,
    SRL_OP = 3'd4,
    SRA_OP = 3'd5,
    OR_OP  = 3'd6,
    AND_OP = 3'd7
  } alu_op_t;

  typedef struct packed {
    alu_op_t        op;
    logic [DPW-1:0] a;
    logic [DPW-1:0] b;
    logic [4:0]     rd;
    logic           we;
    logic           ill;
  } iss_d_t;

  typedef struct packed {
    logic [4:0]     rd;
    logic [DPW-1:0] data;
    logic           we;
    logic           ill;
  } iss_w_t;

endpackage

// File: rtl/rv32i_alu_issue_if.sv
// Bus of the ALU issue block: instruction input handshake,
// ALU drive/return and result output handshake.
// slave = issue block view, master = surrounding pipeline view.
interface rv32i_alu_issue_if #(
  parameter int DPW = 32,
  parameter int PCW = 32
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             in_instr;
  logic [PCW-1:0]          in_pc;
  logic [DPW-1:0]          in_rs1;
  logic [DPW-1:0]          in_rs2;

  logic [DPW-1:0]          alu_opr_a;
  logic [DPW-1:0]          alu_opr_b;
  rv32i_pkg::alu_op_t      alu_opcode;
  logic [DPW-1:0]          alu_res;

  logic                    out_valid;
  logic                    out_ready;
  logic [4:0]              out_rd;
  logic [DPW-1:0]          out_data;
  logic                    out_we;
  logic                    out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1, in_rs2,
    output in_ready,
    output alu_opr_a, alu_opr_b, alu_opcode,
    input  alu_res,
    output out_valid, out_rd, out_data, out_we, out_illegal,
    input  out_ready
  );

  modport master (
    output in_valid, in_instr, in_pc, in_rs1, in_rs2,
    input  in_ready,
    input  alu_opr_a, alu_opr_b, alu_opcode,
    output alu_res,
    input  out_valid, out_rd, out_data, out_we, out_illegal,
    output out_ready
  );

endinterface

// File: rtl/rv32i_alu_issue.sv
// Execute-stage ALU issue: decode -> D reg -> alu -> W reg, valid/ready
// both ends. Ports: clk, arst_n, bus (slave), perf_* if RV32I_ALU_ISSUE_PERF_EN.
module rv32i_alu_issue
  import rv32i_pkg::*;
#(
  parameter int DPW = 32,
  parameter int PCW = 32
) (
  input  logic        clk,
  input  logic        arst_n,
`ifdef RV32I_ALU_ISSUE_PERF_EN
  output logic [31:0] perf_issued,
  output logic [31:0] perf_illegal,
  output logic [31:0] perf_stall,
`endif
  rv32i_alu_issue_if.slave bus
);

  logic [31:0] w_instr;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic        w_is_r;
  logic        w_is_i;
  logic        w_is_lui;
  logic        w_is_auipc;
  logic        w_is_sh;
  logic [3:0]  w_dec;
  logic [DPW-1:0] w_uimm;
  iss_d_t      w_d;
  logic        w_adv;
  logic        w_in_fire;

  iss_d_t      r_d;
  logic        r_d_valid;
  iss_w_t      r_w;
  logic        r_out_valid;

  // {illegal, op}; immediate forms ignore funct7 except on shifts
  function automatic logic [3:0] f_dec(
    input logic [2:0] f3,
    input logic [6:0] f7,
    input logic       imm
  );
    logic z;
    logic alt;
    z = (f7 == 7'b0000000);
    alt = (f7 == 7'b0100000);
    f_dec = {1'b1, ADD_OP};
    case (f3)
      3'b000: begin
        if (imm || z) f_dec = {1'b0, ADD_OP};
        else if (alt) f_dec = {1'b0, SUB_OP};
      end
      3'b001: if (z) f_dec = {1'b0, SLL_OP};
      3'b100: if (imm || z) f_dec = {1'b0, XOR_OP};
      3'b101: begin
        if (z) f_dec = {1'b0, SRL_OP};
        else if (alt) f_dec = {1'b0, SRA_OP};
      end
      3'b110: if (imm || z) f_dec = {1'b0, OR_OP};
      3'b111: if (imm || z) f_dec = {1'b0, AND_OP};
      default: ;
    endcase
  endfunction

  assign w_instr    = bus.in_instr;
  assign w_opc      = w_instr[6:0];
  assign w_f3       = w_instr[14:12];
  assign w_f7       = w_instr[31:25];
  assign w_is_r     = (w_opc == 7'b0110011);
  assign w_is_i     = (w_opc == 7'b0010011);
  assign w_is_lui   = (w_opc == 7'b0110111);
  assign w_is_auipc = (w_opc == 7'b0010111);
  assign w_is_sh    = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  assign w_dec      = f_dec(w_f3, w_f7, w_is_i);
  assign w_uimm     = DPW'($signed({w_instr[31:12], 12'b0}));

  always_comb begin
    w_d    = '0;
    w_d.op = ADD_OP;
    w_d.rd = w_instr[11:7];
    unique case (1'b1)
      w_is_r: begin
        w_d.op  = alu_op_t'(w_dec[2:0]);
        w_d.ill = w_dec[3];
        w_d.a   = bus.in_rs1;
        w_d.b   = bus.in_rs2;
      end
      w_is_i: begin
        w_d.op  = alu_op_t'(w_dec[2:0]);
        w_d.ill = w_dec[3];
        w_d.a   = bus.in_rs1;
        w_d.b   = w_is_sh ? DPW'(w_instr[24:20])
                          : DPW'($signed(w_instr[31:20]));
      end
      w_is_lui: begin
        w_d.b = w_uimm;
      end
      w_is_auipc: begin
        w_d.a = DPW'(bus.in_pc);
        w_d.b = w_uimm;
      end
      default: w_d.ill = 1'b1;
    endcase
    // illegal ops still travel, as a harmless 0+0
    if (w_d.ill) begin
      w_d.op = ADD_OP;
      w_d.a  = '0;
      w_d.b  = '0;
    end
    w_d.we = !w_d.ill && (w_d.rd != 5'd0);
  end

  assign w_adv     = !r_out_valid || bus.out_ready;
  assign w_in_fire = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_d_valid <= 1'b0;
      r_d       <= '0;
    end else if (w_in_fire) begin
      r_d_valid <= 1'b1;
      r_d       <= w_d;
    end else if (w_adv) begin
      r_d_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_out_valid <= 1'b0;
      r_w         <= '0;
    end else if (w_adv) begin
      r_out_valid <= r_d_valid;
      if (r_d_valid) begin
        r_w.rd   <= r_d.rd;
        r_w.data <= r_d.ill ? '0 : bus.alu_res;
        r_w.we   <= r_d.we;
        r_w.ill  <= r_d.ill;
      end
    end
  end

  assign bus.in_ready    = !r_d_valid || w_adv;
  assign bus.alu_opr_a   = r_d.a;
  assign bus.alu_opr_b   = r_d.b;
  assign bus.alu_opcode  = r_d.op;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_rd      = r_w.rd;
  assign bus.out_data    = r_w.data;
  assign bus.out_we      = r_w.we;
  assign bus.out_illegal = r_w.ill;

`ifdef RV32I_ALU_ISSUE_PERF_EN
  logic        w_out_fire;
  logic [31:0] r_perf_iss;
  logic [31:0] r_perf_ill;
  logic [31:0] r_perf_stall;

  assign w_out_fire = r_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_perf_iss   <= '0;
      r_perf_ill   <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_out_fire)
        r_perf_iss <= r_perf_iss + 32'd1;
      if (w_out_fire && r_w.ill)
        r_perf_ill <= r_perf_ill + 32'd1;
      if (r_out_valid && !bus.out_ready)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_issued  = r_perf_iss;
  assign perf_illegal = r_perf_ill;
  assign perf_stall   = r_perf_stall;
`else
  // no event counters in this build
`endif

endmodule
